// File: rtl/mem_port_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter_if                                                  |
// | Fetch, load/store and shared-memory signal bundle for the arbiter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter                                                     |
// | Shares one single-port memory between fetch and load/store ports.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_starve;
  logic                r_owner_ls;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [3:0]          r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;
  logic                r_if_rvalid;
  logic                r_ls_rvalid;

  logic                w_idle;
  logic                w_starved;
  logic                w_if_gnt;
  logic                w_ls_gnt;

  // Grants are only offered from IDLE, and never while reset is held.
  assign w_idle    = rst && (r_state == IDLE);
  assign w_starved = (r_starve == c_LIMIT);
  assign w_if_gnt  = w_idle && bus.if_req && (!bus.ls_req || w_starved);
  assign w_ls_gnt  = w_idle && bus.ls_req && !w_if_gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_owner_ls  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_if_gnt) begin
            r_owner_ls  <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'hF;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
            r_starve    <= '0;
            r_state     <= BUSY;
          end else if (w_ls_gnt) begin
            r_owner_ls  <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.ls_we;
            r_mem_be    <= bus.ls_be;
            r_mem_addr  <= bus.ls_addr;
            r_mem_wdata <= bus.ls_wdata;
            // Only grants that bypass a waiting fetch count toward starvation.
            if (bus.if_req && !w_starved) begin
              r_starve <= r_starve + 1'b1;
            end
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_owner_ls) begin
              r_ls_rvalid <= 1'b1;
              if (!r_mem_we) begin
                r_ls_rdata <= bus.mem_rdata;
              end
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_rdata;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_if_rvalid <= 1'b0;
          r_ls_rvalid <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_mem_req   <= 1'b0;
          r_if_rvalid <= 1'b0;
          r_ls_rvalid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                  |
// | Directed stimulus with a transaction-level reference model.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;
  localparam logic [31:0] c_PAT = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: ack after mem_wait extra cycles, data derived from address.
  int          mem_wait  = 0;
  int          mem_cnt   = 0;
  bit          mem_fixed = 0;
  logic [31:0] fixed_data = '0;
  bit          stray_ack = 0;

  always @(posedge clk) begin
    #1;
    if (bus.mem_req) begin
      bus.mem_ack = (mem_cnt == mem_wait);
      mem_cnt     = bus.mem_ack ? 0 : mem_cnt + 1;
    end else begin
      bus.mem_ack = stray_ack;
      mem_cnt     = 0;
    end
    bus.mem_rdata = mem_fixed ? fixed_data : (bus.mem_addr ^ c_PAT);
  end

  // Reference model: outputs the arbiter must show, kept as a transaction record.
  bit          started = 0;
  logic        e_mem_req, e_we, e_owner_ls, e_if_rv, e_ls_rv;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_ls_rdata;
  int          starve;

  int          cyc = 0;
  int          last_if_gnt = -1, last_ls_gnt = -1, last_if_rv = -1, mr_rise = -1;
  int          if_rv_cnt = 0, ls_rv_cnt = 0, memreq_cycles = 0, grant_n = 0;
  logic [63:0] grant_bits = '0;
  logic        prev_mem_req = 1'b0;

  always @(negedge clk) begin
    logic idle, x_if, x_ls;
    cyc++;
    idle = rst && started && !e_mem_req && !e_if_rv && !e_ls_rv;
    x_if = idle && bus.if_req && (!bus.ls_req || starve >= LIMIT);
    x_ls = idle && bus.ls_req && !x_if;

    if (started) begin
      chk("if_gnt", bus.if_gnt, x_if);
      chk("ls_gnt", bus.ls_gnt, x_ls);
      chk("if_rvalid", bus.if_rvalid, e_if_rv);
      chk("ls_rvalid", bus.ls_rvalid, e_ls_rv);
      chk("if_rdata", bus.if_rdata, e_if_rdata);
      chk("ls_rdata", bus.ls_rdata, e_ls_rdata);
      chk("mem_req", bus.mem_req, e_mem_req);
      if (e_mem_req) begin
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, e_addr);
        if (e_owner_ls) chk("mem_be", bus.mem_be, e_be);
        if (e_owner_ls && e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
      end
    end

    if (bus.if_gnt) begin last_if_gnt = cyc; grant_bits = {grant_bits[62:0], 1'b0}; grant_n++; end
    if (bus.ls_gnt) begin last_ls_gnt = cyc; grant_bits = {grant_bits[62:0], 1'b1}; grant_n++; end
    if (bus.if_rvalid === 1'b1) begin last_if_rv = cyc; if_rv_cnt++; end
    if (bus.ls_rvalid === 1'b1) ls_rv_cnt++;
    if (bus.mem_req === 1'b1) memreq_cycles++;
    if (bus.mem_req === 1'b1 && !prev_mem_req) mr_rise = cyc;
    prev_mem_req = (bus.mem_req === 1'b1);

    if (!rst) begin
      e_mem_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0; e_owner_ls = 0;
      e_if_rv = 0; e_ls_rv = 0; e_if_rdata = 0; e_ls_rdata = 0; starve = 0;
      started = 1;
    end else if (started) begin
      if (e_if_rv || e_ls_rv) begin
        e_if_rv = 0; e_ls_rv = 0;
      end else if (e_mem_req) begin
        if (bus.mem_ack) begin
          e_mem_req = 0;
          if (e_owner_ls) begin
            e_ls_rv = 1;
            if (!e_we) e_ls_rdata = bus.mem_rdata;
          end else begin
            e_if_rv = 1;
            e_if_rdata = bus.mem_rdata;
          end
        end
      end else if (x_if) begin
        e_mem_req = 1; e_owner_ls = 0; e_we = 0; e_addr = bus.if_addr; starve = 0;
      end else if (x_ls) begin
        e_mem_req = 1; e_owner_ls = 1; e_we = bus.ls_we; e_be = bus.ls_be;
        e_addr = bus.ls_addr; e_wdata = bus.ls_wdata;
        if (bus.if_req && starve < LIMIT) starve++;
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    bit got = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.if_gnt;
    end
    if (!got) begin
      errors++;
      $display("FAIL if_gnt_timeout: got no grant, required a grant within 100 cycles");
    end
    @(posedge clk);
    #1 bus.if_req = 1'b0;
  endtask

  task automatic ls_op(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    bus.ls_req   = 1'b1;
    bus.ls_we    = we;
    bus.ls_be    = be;
    bus.ls_addr  = a;
    bus.ls_wdata = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.ls_gnt;
    end
    if (!got) begin
      errors++;
      $display("FAIL ls_gnt_timeout: got no grant, required a grant within 100 cycles");
    end
    @(posedge clk);
    #1 bus.ls_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int snap_if, snap_ls, snap_gn;
    bus.if_req = 0; bus.if_addr = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_be = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    rst = 1'b0;
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(1);
    chk("reset_mem_req", bus.mem_req, 1'b0);
    chk("reset_ls_rdata", bus.ls_rdata, 32'h0);

    // Single fetch with immediate ack
    mem_fixed = 1; fixed_data = 32'h0050_0093;
    fetch(32'h10);
    idle_cycles(4);
    mem_fixed = 0;
    chk("fetch_memreq_latency", mr_rise - last_if_gnt, 1);
    chk("fetch_rvalid_latency", last_if_rv - last_if_gnt, 2);
    chk("fetch_rdata", bus.if_rdata, 32'h0050_0093);

    // Simultaneous requests: load wins, fetch at next IDLE
    grant_bits = '0; grant_n = 0;
    fork
      fetch(32'h20);
      ls_op(1'b0, 4'hF, 32'h100, 32'h0);
    join
    idle_cycles(4);
    chk("simul_order", grant_bits, 64'b10);
    chk("simul_spacing", last_if_gnt - last_ls_gnt, 3);
    chk("simul_ls_rdata", bus.ls_rdata, 32'hA5A5_0100);
    chk("simul_if_rdata", bus.if_rdata, 32'hA5A5_0020);

    // Starvation: 4 loads, then the waiting fetch, then the rest
    grant_bits = '0; grant_n = 0;
    fork
      fetch(32'h40);
      for (int i = 0; i < 6; i++) ls_op(1'b0, 4'hF, 32'h300 + 32'(i * 4), 32'h0);
    join
    idle_cycles(4);
    chk("starve_order", grant_bits, 64'b1111011);
    chk("starve_grants", grant_n, 7);
    chk("starve_ls_rdata", bus.ls_rdata, 32'hA5A5_0314);

    // Store with two wait cycles
    mem_wait = 2; memreq_cycles = 0; snap_ls = ls_rv_cnt;
    ls_op(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
    idle_cycles(6);
    chk("store_memreq_cycles", memreq_cycles, 3);
    chk("store_rvalid_count", ls_rv_cnt - snap_ls, 1);
    chk("store_ls_rdata_held", bus.ls_rdata, 32'hA5A5_0314);

    // Fetch request withdrawn before it could be granted
    mem_wait = 3; snap_gn = grant_n; memreq_cycles = 0;
    ls_op(1'b0, 4'hF, 32'h500, 32'h0);
    bus.if_req = 1'b1; bus.if_addr = 32'h60;
    idle_cycles(2);
    bus.if_req = 1'b0;
    idle_cycles(6);
    chk("withdraw_grants", grant_n - snap_gn, 1);
    chk("withdraw_memreq_cycles", memreq_cycles, 4);

    // Reset in the middle of BUSY
    mem_wait = 5; snap_if = if_rv_cnt; snap_ls = ls_rv_cnt;
    ls_op(1'b0, 4'hF, 32'h400, 32'h0);
    chk("pre_reset_mem_req", bus.mem_req, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy_mem_req", bus.mem_req, 1'b0);
    idle_cycles(6);
    chk("reset_busy_no_rvalid", (if_rv_cnt - snap_if) + (ls_rv_cnt - snap_ls), 0);
    chk("reset_busy_ls_rdata", bus.ls_rdata, 32'h0);
    mem_wait = 0;
    fetch(32'h50);
    idle_cycles(4);
    chk("post_reset_fetch", bus.if_rdata, 32'hA5A5_0050);

    // Stray acknowledge while idle
    snap_if = if_rv_cnt; snap_ls = ls_rv_cnt;
    stray_ack = 1;
    idle_cycles(3);
    stray_ack = 0;
    idle_cycles(2);
    chk("stray_ack_rvalid", (if_rv_cnt - snap_if) + (ls_rv_cnt - snap_ls), 0);
    chk("stray_ack_mem_req", bus.mem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at 200000, required completion earlier");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width of all data ports.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive load/store grants after which a waiting fetch wins.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 if_req  in  1  fetch request, held high until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch word address, sampled in the if_gnt cycle.
REQ-008 if_gnt  out  1  one-cycle fetch grant.
REQ-009 if_rvalid  out  1  one-cycle pulse: if_rdata valid.
REQ-010 if_rdata  out  DATA_W  fetched instruction word.
REQ-011 ls_req  in  1  load/store request, held high until ls_gnt.
REQ-012 ls_we  in  1  1 = store, 0 = load; sampled with ls_addr.
REQ-013 ls_be  in  4  byte enables; sampled with ls_addr.
REQ-014 ls_addr  in  ADDR_W  data address, sampled in the ls_gnt cycle.
REQ-015 ls_wdata  in  DATA_W  store data, sampled in the ls_gnt cycle.
REQ-016 ls_gnt  out  1  one-cycle load/store grant.
REQ-017 ls_rvalid  out  1  one-cycle pulse: load data valid or store complete.
REQ-018 ls_rdata  out  DATA_W  load data; for stores holds its previous value.
REQ-019 mem_req  out  1  request to the shared single-port memory, held until mem_ack.
REQ-020 mem_we, mem_be[3:0], mem_addr[ADDR_W], mem_wdata[DATA_W]  out  latched transaction fields, stable while mem_req=1.
REQ-021 mem_ack  in  1  memory completion; may be asserted in the first cycle of mem_req.
REQ-022 mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.

Function
REQ-023 The block SHALL implement FSM states IDLE, BUSY, RESP.
REQ-024 In IDLE with at least one request high, the block SHALL assert exactly one grant combinationally, latch that requester's fields and an owner flag, and move to BUSY.
REQ-025 Arbitration SHALL give ls_req priority over if_req, except when the starve counter equals STARVE_LIMIT and if_req is high, in which case the fetch SHALL win.
REQ-026 The starve counter SHALL increment, saturating at STARVE_LIMIT, on each ls grant while if_req is high, and SHALL clear on every if grant.
REQ-027 In BUSY, the block SHALL hold mem_req=1 and mem_we=0 for fetches; on mem_ack it SHALL register mem_rdata into the owner's rdata (loads and fetches only) and move to RESP.
REQ-028 In RESP, the block SHALL pulse the owner's rvalid for exactly one cycle, deassert mem_req, and return to IDLE; no grant is issued in RESP.
REQ-029 Minimum transaction spacing SHALL be 3 cycles: grant, BUSY (ack), RESP; each extra mem_ack wait adds one cycle.
REQ-030 mem_ack outside BUSY SHALL be ignored.
REQ-031 Request deasserted before its grant SHALL produce no memory access.
REQ-032 if_gnt and ls_gnt SHALL never be high together; if_rvalid and ls_rvalid SHALL never be high together.
REQ-033 if_rdata and ls_rdata SHALL hold their value between rvalid pulses.

Reset
REQ-034 With rst=0 at a rising edge, the next state SHALL be IDLE, the starve counter 0, and mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, ls_rdata, if_rvalid, ls_rvalid all 0.
REQ-035 While rst=0, if_gnt and ls_gnt SHALL be 0.
REQ-036 Reset during BUSY or RESP SHALL abandon the transaction: no rvalid pulse, mem_req low the cycle after reset is sampled.

Verification
REQ-037 Single fetch: if_req, if_addr=0x10, mem_ack in the first BUSY cycle, mem_rdata=0x00500093 -> if_gnt at cycle 0, mem_req at cycle 1, if_rvalid with if_rdata=0x00500093 at cycle 2.
REQ-038 Simultaneous requests: if_req and ls_req (load 0x100) both high in IDLE -> ls_gnt first; if_gnt at the next IDLE.
REQ-039 Starvation: if_req held high, ls_req held high with 6 loads -> exactly 4 ls grants, then if_gnt, then remaining ls grants.
REQ-040 Store with 2 wait cycles: ls_we=1, ls_be=0b0011, ls_addr=0x200, ls_wdata=0xDEADBEEF -> mem_req high 3 cycles with those fields; ls_rvalid pulses once; ls_rdata unchanged.
REQ-041 Reset mid-BUSY: rst=0 while mem_req=1 -> mem_req=0 the next cycle; no rvalid; the starve counter is 0; the next request is granted normally.
REQ-042 Stray ack: mem_ack=1 in IDLE with no requests -> no rvalid and no state change.
